tt_mux_ctrl: RTL and testbench

Upstream selection stage for the project wrappers in the mux experiment. It receives the shared 18-bit pad input bundle ({uio_in, ui_in, rst_n, clk}) and selection controls from the pads. It broadcasts the bundle to every wrapper, drives each wrapper's ena one-hot, and returns the selected wrapper's 24-bit output bundle ({uio_oe, uio_out, uo_out}). Every project switch is preceded by a guard interval: all projects are disabled and held in reset before the new project is enabled.

---
 rtl/tt_mux_ctrl.sv | 156 +++++++++++++++
 tb/tb_tt_mux_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tt_mux_ctrl
// Brief    : Project selection stage for the mux experiment. Broadcasts the
//            pad input bundle, drives a one-hot project enable, returns the
//            selected project's output bundle, and inserts a guard interval
//            (all projects disabled and held in reset) on every switch.
// Revision : 1.0 - initial release
// ============================================================================
module tt_mux_ctrl #(
  parameter int NUM_PROJ = 16,
  parameter int ADDR_W   = 4,
  parameter int IW       = 18,
  parameter int OW       = 24,
  parameter int GUARD    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_ena,
  input  logic                   ctrl_sel_rst,
  input  logic                   ctrl_sel_inc,
  input  logic [IW-1:0]          iw_in,
  output logic [IW-1:0]          iw_out,
  output logic [NUM_PROJ-1:0]    ena_out,
  input  logic [NUM_PROJ*OW-1:0] ow_bus,
  output logic [OW-1:0]          ow_out,
  output logic [ADDR_W-1:0]      addr,
  output logic                   active
);

  localparam int CW = (GUARD > 1) ? $clog2(GUARD) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SWITCH = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CW-1:0]       guard_cnt;
  logic [CW-1:0]       guard_nxt;
  logic                inc_q;
  logic                inc_edge;
  logic                sel_evt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [NUM_PROJ-1:0] ena_nxt;
  logic                active_nxt;
  logic [OW-1:0]       ow_sel;
  logic [OW-1:0]       ow_nxt;

  // A select event is a level on sel_rst or a fresh rising edge on sel_inc.
  assign inc_edge = ctrl_sel_inc & ~inc_q;
  assign sel_evt  = ctrl_sel_rst | inc_edge;

  // Next address: sel_rst wins over a simultaneous inc edge; increment wraps.
  always_comb begin
    addr_nxt = addr;
    if (ctrl_sel_rst) begin
      addr_nxt = '0;
    end else if (inc_edge) begin
      if (addr == ADDR_W'(NUM_PROJ - 1)) begin
        addr_nxt = '0;
      end else begin
        addr_nxt = addr + ADDR_W'(1);
      end
    end
  end

  // State, guard counter, address and inc-edge history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      guard_cnt <= '0;
      addr      <= '0;
      inc_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      guard_cnt <= guard_nxt;
      addr      <= addr_nxt;
      inc_q     <= ctrl_sel_inc;
    end
  end

  // Next-state logic: every select event restarts the guard interval.
  always_comb begin
    state_nxt = state;
    guard_nxt = guard_cnt;
    if (!ctrl_ena) begin
      state_nxt = S_IDLE;
      guard_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_SWITCH;
          guard_nxt = '0;
        end
        S_SWITCH: begin
          if (sel_evt) begin
            guard_nxt = '0;
          end else if (guard_cnt == CW'(GUARD - 1)) begin
            state_nxt = S_ACTIVE;
            guard_nxt = '0;
          end else begin
            guard_nxt = guard_cnt + CW'(1);
          end
        end
        S_ACTIVE: begin
          if (sel_evt) begin
            state_nxt = S_SWITCH;
            guard_nxt = '0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          guard_nxt = '0;
        end
      endcase
    end
  end

  // Pick the current project's slice out of the concatenated output bus.
  always_comb begin
    ow_sel = '0;
    for (int k = 0; k < NUM_PROJ; k++) begin
      if (addr == ADDR_W'(k)) begin
        ow_sel = ow_bus[k*OW +: OW];
      end
    end
  end

  // Output decode: enable and active follow the next state so they line up
  // with the state register; ow_out samples the current selection.
  always_comb begin
    active_nxt = (state_nxt == S_ACTIVE);
    ena_nxt    = active_nxt ? (NUM_PROJ'(1) << addr_nxt) : '0;
    ow_nxt     = (state == S_ACTIVE) ? ow_sel : '0;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ena_out <= '0;
      active  <= 1'b0;
      ow_out  <= '0;
    end else begin
      ena_out <= ena_nxt;
      active  <= active_nxt;
      ow_out  <= ow_nxt;
    end
  end

  // Unregistered so the projects see the pad clock undivided; zero keeps
  // their clk and rst_n low whenever no project is active.
  assign iw_out = (state == S_ACTIVE) ? iw_in : '0;

endmodule
`default_nettype wire

// File: tb/tb_tt_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_mux_ctrl
// Brief    : Self-checking bench for tt_mux_ctrl: vector table, directed
//            corner sequences and random stimulus against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_mux_ctrl;

  localparam int NUM_PROJ = 16;
  localparam int ADDR_W   = 4;
  localparam int IW       = 18;
  localparam int OW       = 24;
  localparam int GUARD    = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ctrl_ena;
  logic                   ctrl_sel_rst;
  logic                   ctrl_sel_inc;
  logic [IW-1:0]          iw_in;
  logic [IW-1:0]          iw_out;
  logic [NUM_PROJ-1:0]    ena_out;
  logic [NUM_PROJ*OW-1:0] ow_bus;
  logic [OW-1:0]          ow_out;
  logic [ADDR_W-1:0]      addr;
  logic                   active;

  tt_mux_ctrl #(
    .NUM_PROJ(NUM_PROJ), .ADDR_W(ADDR_W), .IW(IW), .OW(OW), .GUARD(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .ctrl_ena(ctrl_ena), .ctrl_sel_rst(ctrl_sel_rst),
    .ctrl_sel_inc(ctrl_sel_inc), .iw_in(iw_in), .iw_out(iw_out),
    .ena_out(ena_out), .ow_bus(ow_bus), .ow_out(ow_out), .addr(addr),
    .active(active)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: "guard cycles remaining" view of the selection stage.
  int            m_addr;
  bit            m_idle;
  int            m_left;
  bit            m_prev_inc;
  bit            m_active;
  logic [OW-1:0] m_ow;

  task automatic step();
    logic [OW-1:0] ow_e;
    bit evt_inc;
    bit evt;
    @(posedge clk);
    if (rst) begin
      m_addr = 0; m_idle = 1; m_left = 0; m_prev_inc = 0; m_active = 0; m_ow = '0;
    end else begin
      ow_e    = m_active ? ow_bus[m_addr*OW +: OW] : '0;
      evt_inc = ctrl_sel_inc && !m_prev_inc;
      evt     = ctrl_sel_rst || evt_inc;
      if (ctrl_sel_rst) m_addr = 0;
      else if (evt_inc) m_addr = (m_addr + 1) % NUM_PROJ;
      if (!ctrl_ena) begin
        m_idle = 1; m_left = 0;
      end else if (m_idle) begin
        m_idle = 0; m_left = GUARD;
      end else if (evt) begin
        m_left = GUARD;
      end else if (m_left > 0) begin
        m_left--;
      end
      m_prev_inc = ctrl_sel_inc;
      m_active   = !m_idle && (m_left == 0);
      m_ow       = ow_e;
    end
    #1;
    chk("addr", 64'(addr), 64'(m_addr));
    chk("active", 64'(active), 64'(m_active));
    chk("ena_out", 64'(ena_out), m_active ? (64'd1 << m_addr) : 64'd0);
    chk("iw_out", 64'(iw_out), m_active ? 64'(iw_in) : 64'd0);
    chk("ow_out", 64'(ow_out), 64'(m_ow));
  endtask

  task automatic pulse_inc(int n);
    for (int i = 0; i < n; i++) begin
      ctrl_sel_inc = 1'b1; step();
      ctrl_sel_inc = 1'b0; step();
    end
  endtask

  task automatic wait_active();
    for (int i = 0; i < 20 && !m_active; i++) step();
  endtask

  typedef struct {
    bit            ena;
    bit            inc;
    int            exp_addr;
    bit            exp_act;
    logic [OW-1:0] exp_ow;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Enable from reset, guard, then three inc pulses to project 3.
    tbl[0]  = '{1, 0, 0, 0, 24'h0};
    tbl[1]  = '{1, 0, 0, 0, 24'h0};
    tbl[2]  = '{1, 0, 0, 0, 24'h0};
    tbl[3]  = '{1, 0, 0, 0, 24'h0};
    tbl[4]  = '{1, 0, 0, 1, 24'h0};
    tbl[5]  = '{1, 1, 1, 0, 24'h0};
    tbl[6]  = '{1, 0, 1, 0, 24'h0};
    tbl[7]  = '{1, 1, 2, 0, 24'h0};
    tbl[8]  = '{1, 0, 2, 0, 24'h0};
    tbl[9]  = '{1, 1, 3, 0, 24'h0};
    tbl[10] = '{1, 0, 3, 0, 24'h0};
    tbl[11] = '{1, 0, 3, 0, 24'h0};
    tbl[12] = '{1, 0, 3, 0, 24'h0};
    tbl[13] = '{1, 0, 3, 1, 24'h0};
    tbl[14] = '{1, 0, 3, 1, 24'hABCDEF};

    rst = 1'b1; ctrl_ena = 1'b0; ctrl_sel_rst = 1'b0; ctrl_sel_inc = 1'b0;
    iw_in = 18'h2A5F5;
    ow_bus = '0;
    ow_bus[3*OW +: OW] = 24'hABCDEF;
    step(); step();
    chk("reset_ena", 64'(ena_out), 64'd0);
    chk("reset_iw", 64'(iw_out), 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      ctrl_ena = tbl[i].ena; ctrl_sel_inc = tbl[i].inc;
      step();
      chk("tbl_addr", 64'(addr), 64'(tbl[i].exp_addr));
      chk("tbl_active", 64'(active), 64'(tbl[i].exp_act));
      chk("tbl_ena", 64'(ena_out), tbl[i].exp_act ? (64'd1 << tbl[i].exp_addr) : 64'd0);
      chk("tbl_iw", 64'(iw_out), tbl[i].exp_act ? 64'h2A5F5 : 64'd0);
      chk("tbl_ow", 64'(ow_out), 64'(tbl[i].exp_ow));
    end

    // Holding inc high yields a single increment; then wrap 15 -> 0.
    pulse_inc(2); wait_active();
    chk("at5", 64'(addr), 64'd5);
    ctrl_sel_inc = 1'b1;
    for (int i = 0; i < 10; i++) step();
    ctrl_sel_inc = 1'b0; step();
    chk("hold_inc", 64'(addr), 64'd6);
    wait_active();
    pulse_inc(9); wait_active();
    chk("at15", 64'(addr), 64'd15);
    pulse_inc(1); wait_active();
    chk("wrap_addr", 64'(addr), 64'd0);
    chk("wrap_ena", 64'(ena_out), 64'h0001);

    // sel_rst and inc edge in the same cycle.
    pulse_inc(7); wait_active();
    chk("at7", 64'(addr), 64'd7);
    ctrl_sel_rst = 1'b1; ctrl_sel_inc = 1'b1; step();
    chk("rst_inc_addr", 64'(addr), 64'd0);
    chk("rst_inc_guard", 64'(active), 64'd0);
    ctrl_sel_rst = 1'b0; ctrl_sel_inc = 1'b0;
    wait_active();
    chk("rst_inc_ena", 64'(ena_out), 64'h0001);

    // Drop enable mid-guard, then re-raise for a full guard.
    pulse_inc(1);
    ctrl_ena = 1'b0; step();
    chk("drop_active", 64'(active), 64'd0);
    chk("drop_ena", 64'(ena_out), 64'd0);
    step();
    chk("drop_ow", 64'(ow_out), 64'd0);
    ctrl_ena = 1'b1;
    for (int i = 0; i < GUARD; i++) begin
      step();
      chk("reguard", 64'(active), 64'd0);
    end
    step();
    chk("reguard_done", 64'(active), 64'd1);

    // Random stimulus against the model.
    for (int c = 0; c < 500; c++) begin
      ctrl_ena     = ($urandom_range(0, 15) != 0);
      ctrl_sel_rst = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 5) == 0) ctrl_sel_inc = ~ctrl_sel_inc;
      iw_in = IW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < NUM_PROJ; k++) ow_bus[k*OW +: OW] = OW'($urandom);
      end
      step();
    end

    // Reset while active at project 9.
    ctrl_ena = 1'b1; ctrl_sel_inc = 1'b0; ctrl_sel_rst = 1'b1; step();
    ctrl_sel_rst = 1'b0; step();
    pulse_inc(9); wait_active();
    for (int k = 0; k < NUM_PROJ; k++) ow_bus[k*OW +: OW] = OW'(24'h100001 * (k + 1));
    iw_in = 18'h3FFFF;
    step();
    chk("at9", 64'(addr), 64'd9);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_ena", 64'(ena_out), 64'd0);
    chk("rst_ow", 64'(ow_out), 64'd0);
    chk("rst_iw", 64'(iw_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
